// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory bus port between the fetch stage (instruction
// reads) and the memory stage (loads/stores). Only one bus transaction is
// outstanding at a time. The memory stage normally wins arbitration, but a
// streak counter forces a waiting fetch through after STARVE_LIMIT
// consecutive memory-stage grants. A pipeline redirect (if_flush) squashes a
// fetch that is pending or in flight: the bus transaction still runs to
// completion, but its response is never delivered. Bus errors and bus
// timeouts become per-requester fault responses.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   if_req/if_addr     fetch read request, held until if_gnt
//   if_flush           redirect; blocks/cancels the fetch
//   if_gnt             fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata/if_fault   fetch response (1-cycle pulse, data held)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory-stage request
//   mem_gnt            memory-stage request accepted (combinational)
//   mem_rvalid/mem_rdata/mem_fault load/store completion (rdata 0 on stores)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be   registered bus request
//   bus_ack/bus_err/bus_rdata                  bus completion
//   busy               transaction outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_fault,

    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_be,
    output logic            mem_gnt,
    output logic            mem_rvalid,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_fault,

    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_be,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [DW-1:0]   bus_rdata,

    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_F    = 2'd1,
        BUSY_F_SQ = 2'd2,
        BUSY_M    = 2'd3
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   streak_r;
    logic [TW-1:0]   tcnt_r;

    logic            bus_req_r;
    logic            bus_we_r;
    logic [AW-1:0]   bus_addr_r;
    logic [DW-1:0]   bus_wdata_r;
    logic [BW-1:0]   bus_be_r;
    logic            busy_r;

    logic            if_rvalid_r;
    logic [DW-1:0]   if_rdata_r;
    logic            if_fault_r;
    logic            mem_rvalid_r;
    logic [DW-1:0]   mem_rdata_r;
    logic            mem_fault_r;

    logic            if_gnt_s;
    logic            mem_gnt_s;
    logic            fetch_ok_s;
    logic            starved_s;
    logic            timeout_s;

    // Completion data for the requester: stores return zero.
    function automatic logic [DW-1:0] resp_data(input logic we, input logic [DW-1:0] rdata);
        if (we) begin
            return {DW{1'b0}};
        end else begin
            return rdata;
        end
    endfunction

    assign fetch_ok_s = if_req && !if_flush;
    assign starved_s  = (streak_r == SW'(STARVE_LIMIT));
    // The counter starts at 0 on the first BUSY cycle, so the abort fires in
    // the cycle where it has counted TIMEOUT cycles without an ack.
    assign timeout_s  = (tcnt_r == TW'(TIMEOUT));

    // Grant decision: only in IDLE; memory stage wins unless fetch is starved.
    always_comb begin
        if_gnt_s  = 1'b0;
        mem_gnt_s = 1'b0;
        if (state_r == IDLE) begin
            if (mem_req && fetch_ok_s) begin
                if (starved_s) begin
                    if_gnt_s = 1'b1;
                end else begin
                    mem_gnt_s = 1'b1;
                end
            end else if (mem_req) begin
                mem_gnt_s = 1'b1;
            end else if (fetch_ok_s) begin
                if_gnt_s = 1'b1;
            end else begin
                if_gnt_s  = 1'b0;
                mem_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s  = 1'b0;
            mem_gnt_s = 1'b0;
        end
    end

    // Starvation streak: counts memory grants that overtook a live fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_r <= {SW{1'b0}};
        end else if (!if_req || if_gnt_s) begin
            streak_r <= {SW{1'b0}};
        end else if (mem_gnt_s && !if_flush && !starved_s) begin
            streak_r <= streak_r + SW'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

    // Transaction FSM: latches the bus request, waits for ack/timeout and
    // produces the registered per-requester response pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            tcnt_r       <= {TW{1'b0}};
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= {AW{1'b0}};
            bus_wdata_r  <= {DW{1'b0}};
            bus_be_r     <= {BW{1'b0}};
            busy_r       <= 1'b0;
            if_rvalid_r  <= 1'b0;
            if_rdata_r   <= {DW{1'b0}};
            if_fault_r   <= 1'b0;
            mem_rvalid_r <= 1'b0;
            mem_rdata_r  <= {DW{1'b0}};
            mem_fault_r  <= 1'b0;
        end else begin
            if_rvalid_r  <= 1'b0;
            mem_rvalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tcnt_r <= {TW{1'b0}};
                    if (mem_gnt_s) begin
                        state_r     <= BUSY_M;
                        bus_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        bus_we_r    <= mem_we;
                        bus_addr_r  <= mem_addr;
                        bus_wdata_r <= mem_wdata;
                        bus_be_r    <= mem_be;
                    end else if (if_gnt_s) begin
                        state_r     <= BUSY_F;
                        bus_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        bus_we_r    <= 1'b0;
                        bus_addr_r  <= if_addr;
                        bus_wdata_r <= {DW{1'b0}};
                        bus_be_r    <= {BW{1'b1}};
                    end else begin
                        // Stray bus_ack here is deliberately ignored.
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end

                BUSY_F: begin
                    if (bus_ack || timeout_s) begin
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                        // A redirect in the completing cycle still squashes.
                        if (!if_flush) begin
                            if_rvalid_r <= 1'b1;
                            if (bus_ack) begin
                                if_rdata_r <= bus_rdata;
                                if_fault_r <= bus_err;
                            end else begin
                                if_rdata_r <= {DW{1'b0}};
                                if_fault_r <= 1'b1;
                            end
                        end else begin
                            if_rvalid_r <= 1'b0;
                        end
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                        state_r <= if_flush ? BUSY_F_SQ : BUSY_F;
                    end
                end

                BUSY_F_SQ: begin
                    // Let the bus finish, but drop the response.
                    if (bus_ack || timeout_s) begin
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                        state_r <= BUSY_F_SQ;
                    end
                end

                BUSY_M: begin
                    if (bus_ack) begin
                        state_r      <= IDLE;
                        bus_req_r    <= 1'b0;
                        busy_r       <= 1'b0;
                        mem_rvalid_r <= 1'b1;
                        mem_rdata_r  <= resp_data(bus_we_r, bus_rdata);
                        mem_fault_r  <= bus_err;
                    end else if (timeout_s) begin
                        state_r      <= IDLE;
                        bus_req_r    <= 1'b0;
                        busy_r       <= 1'b0;
                        mem_rvalid_r <= 1'b1;
                        mem_rdata_r  <= {DW{1'b0}};
                        mem_fault_r  <= 1'b1;
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                        state_r <= BUSY_M;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    bus_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = if_gnt_s;
    assign mem_gnt    = mem_gnt_s;
    assign if_rvalid  = if_rvalid_r;
    assign if_rdata   = if_rdata_r;
    assign if_fault   = if_fault_r;
    assign mem_rvalid = mem_rvalid_r;
    assign mem_rdata  = mem_rdata_r;
    assign mem_fault  = mem_fault_r;
    assign bus_req    = bus_req_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign bus_be     = bus_be_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter: a table of single-transaction vectors plus
// hand-written sequences for reset, latency, starvation, flush and timeout.
// Responses are predicted when the bus ack (or abort) is set up and checked by
// a scoreboard monitor, including the exact cycle they must appear in.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_gnt, if_rvalid, if_fault;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid, mem_fault;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;
    logic          bus_req, bus_we, bus_ack, bus_err, busy;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [BW-1:0] bus_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_fault(if_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_mem;
        logic [63:0] data;
        bit          fault;
        int          at;
    } resp_t;
    resp_t sb[$];
    resp_t mon_e;

    typedef struct {
        logic        if_req;
        logic        if_flush;
        logic        mem_req;
        logic        mem_we;
        logic [7:0]  be;
        logic        err;
        logic [63:0] rdata;
        logic        exp_if_gnt;
        logic        exp_mem_gnt;
    } vec_t;
    vec_t vecs[9];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every response pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (reset === 1'b1 && (if_rvalid === 1'b1 || mem_rvalid === 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid actual if_rvalid=%b mem_rvalid=%b required none (cycle %0d)",
                         if_rvalid, mem_rvalid, cyc);
            end else begin
                mon_e = sb.pop_front();
                if ((if_rvalid && mem_rvalid) || (mem_rvalid !== mon_e.is_mem) || (cyc != mon_e.at) ||
                    ((mon_e.is_mem ? mem_rdata : if_rdata) !== mon_e.data) ||
                    ((mon_e.is_mem ? mem_fault : if_fault) !== mon_e.fault)) begin
                    errors++;
                    $display("FAIL response actual mem=%b if=%b ifdata=%h ifflt=%b memdata=%h memflt=%b cyc=%0d required mem=%b data=%h flt=%b cyc=%0d",
                             mem_rvalid, if_rvalid, if_rdata, if_fault, mem_rdata, mem_fault, cyc,
                             mon_e.is_mem, mon_e.data, mon_e.fault, mon_e.at);
                end
            end
        end
    end

    bit   exp_pat[10];
    logic [63:0] wd;
    int   c0;

    initial begin
        // if_req, if_flush, mem_req, mem_we, be, err, rdata, exp_if_gnt, exp_mem_gnt
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 64'hA5A5_0000_5A5A_FFFF, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 64'h0000_0000_0000_5555, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 64'h0000_0000_BAD0_BAD0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 64'h0000_0000_0000_7777, 1'b0, 1'b1};
        exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b0;
        if_req = 1'b0; if_flush = 1'b0; if_addr = 64'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 64'h0; mem_wdata = 64'h0; mem_be = 8'h00;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 64'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_mem_rvalid", mem_rvalid, 1'b0);
        chk64("rst_if_rdata", if_rdata, 64'h0);
        chk64("rst_mem_rdata", mem_rdata, 64'h0);
        chk1("rst_faults", if_fault | mem_fault, 1'b0);
        chk64("rst_bus_addr", bus_addr, 64'h0);
        chk64("rst_bus_be", 64'(bus_be), 64'h0);
        reset = 1'b1;
        tick();

        // Table-driven single transactions from IDLE, ack at cycle 2
        for (int i = 0; i < 9; i++) begin
            if_req   = vecs[i].if_req;
            if_flush = vecs[i].if_flush;
            mem_req  = vecs[i].mem_req;
            mem_we   = vecs[i].mem_we;
            mem_be   = vecs[i].be;
            if_addr  = 64'h1000 + 64'(i) * 64'd16;
            mem_addr = 64'h8000_0000 + 64'(i) * 64'd16;
            wd       = {32'hC0DE_0000 + 32'(i), 32'h0000_BEEF};
            mem_wdata = wd;
            sample();
            chk1("vec_if_gnt", if_gnt, vecs[i].exp_if_gnt);
            chk1("vec_mem_gnt", mem_gnt, vecs[i].exp_mem_gnt);
            tick();
            if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;
            if (vecs[i].exp_if_gnt || vecs[i].exp_mem_gnt) begin
                sample();
                chk1("vec_bus_req", bus_req, 1'b1);
                chk1("vec_busy", busy, 1'b1);
                if (vecs[i].exp_if_gnt) begin
                    chk64("vec_bus_addr", bus_addr, 64'h1000 + 64'(i) * 64'd16);
                    chk1("vec_bus_we", bus_we, 1'b0);
                    chk64("vec_bus_be", 64'(bus_be), 64'hFF);
                end else begin
                    chk64("vec_bus_addr", bus_addr, 64'h8000_0000 + 64'(i) * 64'd16);
                    chk1("vec_bus_we", bus_we, vecs[i].mem_we);
                    chk64("vec_bus_be", 64'(bus_be), 64'(vecs[i].be));
                    if (vecs[i].mem_we) chk64("vec_bus_wdata", bus_wdata, wd);
                end
                tick();
                bus_ack = 1'b1; bus_err = vecs[i].err; bus_rdata = vecs[i].rdata;
                sb.push_back('{vecs[i].exp_mem_gnt,
                               (vecs[i].exp_mem_gnt && vecs[i].mem_we) ? 64'h0 : vecs[i].rdata,
                               vecs[i].err, cyc + 1});
                tick();
                bus_ack = 1'b0; bus_err = 1'b0;
                sample();
                chk1("vec_bus_req_drop", bus_req, 1'b0);
                tick();
            end else begin
                tick();
            end
        end
        // Response data is held after the pulse (last vector was a clean store)
        chk64("hold_mem_rdata", mem_rdata, 64'h0);
        chk1("hold_mem_fault", mem_fault, 1'b0);

        // Reset in the middle of a fetch
        if_req = 1'b1; if_addr = 64'h4000;
        sample();
        chk1("rstmid_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk1("rstmid_bus_req", bus_req, 1'b0);
        chk1("rstmid_busy", busy, 1'b0);
        bus_ack = 1'b1; bus_rdata = 64'h1234;
        tick();
        bus_ack = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk1("rstmid_idle_busy", busy, 1'b0);
        chk1("rstmid_idle_req", bus_req, 1'b0);

        // Single fetch with ack at cycle 3, response at cycle 4
        if_req = 1'b1; if_addr = 64'h1000;
        c0 = cyc;
        sample();
        chk1("fetch_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        sample();
        chk1("fetch_bus_req", bus_req, 1'b1);
        chk64("fetch_bus_addr", bus_addr, 64'h1000);
        chk1("fetch_bus_we", bus_we, 1'b0);
        tick();
        sample();
        chk1("fetch_no_early_rvalid", if_rvalid, 1'b0);
        tick();
        bus_ack = 1'b1; bus_rdata = 64'h0000_0000_DEAD_BEEF;
        sb.push_back('{1'b0, 64'h0000_0000_DEAD_BEEF, 1'b0, c0 + 4});
        tick();
        bus_ack = 1'b0;
        sample();
        chk1("fetch_rvalid", if_rvalid, 1'b1);
        chk1("fetch_fault", if_fault, 1'b0);
        tick();

        // Contention: both requests held, ack one cycle into each transaction
        if_req = 1'b1; if_addr = 64'h2000; if_flush = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h3000; mem_be = 8'hFF;
        for (int g = 0; g < 10; g++) begin
            sample();
            chk1("starve_mem_gnt", mem_gnt, exp_pat[g]);
            chk1("starve_if_gnt", if_gnt, !exp_pat[g]);
            tick();
            bus_ack = 1'b1; bus_rdata = 64'h100 + 64'(g);
            sb.push_back('{exp_pat[g], 64'h100 + 64'(g), 1'b0, cyc + 1});
            tick();
            bus_ack = 1'b0;
        end
        if_req = 1'b0; mem_req = 1'b0;
        sample();
        tick();

        // Flush squash with a pending memory request
        if_req = 1'b1; if_addr = 64'h5000;
        sample();
        chk1("sq_if_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h6000; mem_be = 8'hFF;
        sample();
        chk1("sq_mem_wait1", mem_gnt, 1'b0);
        tick();
        if_flush = 1'b1;
        sample();
        chk1("sq_mem_wait2", mem_gnt, 1'b0);
        tick();
        if_flush = 1'b0;
        sample();
        chk1("sq_bus_req_held", bus_req, 1'b1);
        tick();
        bus_ack = 1'b1; bus_rdata = 64'hFEED;
        sample();
        chk1("sq_mem_wait4", mem_gnt, 1'b0);
        tick();
        bus_ack = 1'b0;
        sample();
        chk1("sq_mem_gnt_c5", mem_gnt, 1'b1);
        chk1("sq_no_if_rvalid", if_rvalid, 1'b0);
        tick();
        mem_req = 1'b0;
        bus_ack = 1'b1; bus_rdata = 64'hABCD;
        sb.push_back('{1'b1, 64'hABCD, 1'b0, cyc + 1});
        sample();
        chk64("sq_mem_bus_addr", bus_addr, 64'h6000);
        tick();
        bus_ack = 1'b0;
        sample();
        tick();

        // Flush coincident with ack
        if_req = 1'b1; if_addr = 64'h5100;
        sample();
        chk1("sqack_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        tick();
        bus_ack = 1'b1; if_flush = 1'b1; bus_rdata = 64'h7777_7777;
        tick();
        bus_ack = 1'b0; if_flush = 1'b0;
        sample();
        chk1("sqack_no_rvalid", if_rvalid, 1'b0);
        chk1("sqack_idle", busy, 1'b0);
        tick();

        // Timeout: no ack, fault response 9 cycles after bus_req rises
        if_req = 1'b1; if_addr = 64'h7000;
        c0 = cyc;
        sample();
        chk1("to_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        sb.push_back('{1'b0, 64'h0, 1'b1, c0 + 10});
        for (int j = 1; j <= 9; j++) begin
            sample();
            chk1("to_bus_req_held", bus_req, 1'b1);
            tick();
        end
        sample();
        chk1("to_rvalid", if_rvalid, 1'b1);
        chk1("to_fault", if_fault, 1'b1);
        chk1("to_bus_req_drop", bus_req, 1'b0);
        tick();
        bus_ack = 1'b1; bus_rdata = 64'h999;
        sample();
        tick();
        bus_ack = 1'b0;
        sample();
        chk1("stray_ack_idle", busy, 1'b0);
        chk1("stray_fault_held", if_fault, 1'b1);
        chk64("stray_rdata_held", if_rdata, 64'h0);
        tick();
        repeat (2) tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_responses actual=%0d outstanding required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
